// File: rtl/dmtd_scan_ctl_if.sv
// Bus bundle between the DMTD scan sequencer and its surroundings:
// run/phase/error inputs and the mux select, status and result outputs.
interface dmtd_scan_ctl_if #(
    parameter int dw  = 14,
    parameter int nch = 4
);
    localparam int SW = $clog2(nch);

    logic            run;
    logic [dw-2:0]   phdiff_in;
    logic            err_in;
    logic [SW-1:0]   sel;
    logic            busy;
    logic [dw-2:0]   result;
    logic [SW-1:0]   result_ch;
    logic            result_valid;
    logic            fail;
    logic [nch-1:0]  fail_mask;

    modport master (
        output run, phdiff_in, err_in,
        input  sel, busy, result, result_ch, result_valid, fail, fail_mask
    );

    modport slave (
        input  run, phdiff_in, err_in,
        output sel, busy, result, result_ch, result_valid, fail, fail_mask
    );
endinterface

// File: rtl/dmtd_scan_ctl.sv
// DMTD phase scan sequencer: steps the clock-pair mux over nch channels,
// waits for the trackers to settle, averages 2**navg_log2 phase samples
// with wrap-safe differences against the first sample, and publishes one
// result (or a failure) per channel.
// Optional feature macro: DMTD_SCAN_RETRY_EN enables up to max_retry
// re-acquisitions of a channel after a tracker error; without it the
// first error abandons the channel.
module dmtd_scan_ctl #(
    parameter int dw         = 14,
    parameter int nch        = 4,
    parameter int settle     = 2048,
    parameter int sample_per = 64,
    parameter int navg_log2  = 4,
    parameter int max_retry  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    dmtd_scan_ctl_if.slave bus
);
    localparam int PW   = dw - 1;
    localparam int SW   = $clog2(nch);
    localparam int AW   = PW + navg_log2;
    localparam int CMAX = (settle > sample_per) ? settle : sample_per;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int NW   = navg_log2 + 1;
    localparam int NS   = 1 << navg_log2;

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [NW-1:0]         r_nsmp;
    logic [PW-1:0]         r_ref;
    logic [PW-1:0]         r_avg;
    logic signed [AW-1:0]  r_acc;
    logic                  r_failed;
    logic                  r_run_d;
    logic [SW-1:0]         r_sel;
    logic [SW-1:0]         r_result_ch;
    logic [PW-1:0]         r_result;
    logic                  r_result_valid;
    logic                  r_fail;
    logic [nch-1:0]        r_fail_mask;

    logic                  w_run_rise;
    logic                  w_can_retry;
    logic                  w_retry;
    logic                  w_abort;
    logic                  w_take;
    logic                  w_finish;
    logic [PW-1:0]         w_ref_eff;
    logic [PW-1:0]         w_d;
    logic [PW-1:0]         w_avg;
    logic signed [AW-1:0]  w_acc_nxt;
    logic signed [AW-1:0]  w_acc_avg;

    assign w_run_rise = bus.run & ~r_run_d;

    // The first sample becomes the reference, so its difference is zero by
    // construction; later samples wrap modulo 2**PW and are sign-extended.
    assign w_ref_eff = (r_nsmp == '0) ? bus.phdiff_in : r_ref;
    assign w_d       = bus.phdiff_in - w_ref_eff;
    assign w_acc_nxt = r_acc + AW'($signed(w_d));
    assign w_acc_avg = w_acc_nxt >>> navg_log2;
    assign w_avg     = w_ref_eff + w_acc_avg[PW-1:0];

`ifdef DMTD_SCAN_RETRY_EN
    localparam int RW = $clog2(max_retry + 2);
    logic [RW-1:0] r_retry;

    // Re-acquisition counter, reset once the channel is finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
        end else if (r_state == DONE) begin
            r_retry <= '0;
        end else if (w_retry) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    assign w_can_retry = (r_retry < RW'(max_retry));
`else
    assign w_can_retry = 1'b0;
`endif

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_retry     = 1'b0;
        w_abort     = 1'b0;
        w_take      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.run) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE, ACQ: begin
                if (bus.err_in) begin
                    if (w_can_retry) begin
                        w_retry     = 1'b1;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_abort     = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else if (r_state == SETTLE) begin
                    if (r_cnt == CW'(settle - 1)) begin
                        w_state_nxt = ACQ;
                    end
                end else if (r_cnt == CW'(sample_per - 1)) begin
                    w_take = 1'b1;
                    if (r_nsmp == NW'(NS - 1)) begin
                        w_finish    = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = bus.run ? SETTLE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared settle / sample-period counter, restarted on every phase change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_retry || w_take || (w_state_nxt != r_state)) begin
            r_cnt <= '0;
        end else if ((r_state == SETTLE) || (r_state == ACQ)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sample counter, reference, accumulator and pending average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nsmp   <= '0;
            r_ref    <= '0;
            r_acc    <= '0;
            r_avg    <= '0;
            r_failed <= 1'b0;
        end else begin
            if (r_state == SETTLE) begin
                r_nsmp <= '0;
                r_acc  <= '0;
            end else if (w_take) begin
                r_nsmp <= r_nsmp + 1'b1;
                r_ref  <= w_ref_eff;
                r_acc  <= w_acc_nxt;
            end
            if (w_finish) begin
                r_avg <= w_avg;
            end
            if (w_abort) begin
                r_failed <= 1'b1;
            end else if (r_state == DONE) begin
                r_failed <= 1'b0;
            end
        end
    end

    // Published outputs: result/fail and the mux advance all land on the DONE exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_d        <= 1'b0;
            r_sel          <= '0;
            r_result       <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_fail         <= 1'b0;
            r_fail_mask    <= '0;
        end else begin
            r_run_d        <= bus.run;
            r_result_valid <= 1'b0;
            r_fail         <= 1'b0;
            if (w_run_rise) begin
                r_fail_mask <= '0;
            end
            if ((r_state == IDLE) && w_run_rise) begin
                r_sel <= '0;
            end
            if (r_state == DONE) begin
                r_result_ch <= r_sel;
                r_sel       <= (r_sel == SW'(nch - 1)) ? '0 : r_sel + 1'b1;
                if (r_failed) begin
                    r_fail             <= 1'b1;
                    r_fail_mask[r_sel] <= 1'b1;
                end else begin
                    r_result       <= r_avg;
                    r_result_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.sel          = r_sel;
    assign bus.busy         = (r_state != IDLE);
    assign bus.result       = r_result;
    assign bus.result_ch    = r_result_ch;
    assign bus.result_valid = r_result_valid;
    assign bus.fail         = r_fail;
    assign bus.fail_mask    = r_fail_mask;
endmodule

// File: tb/tb_dmtd_scan_ctl.sv
// Testbench for dmtd_scan_ctl: a channel-timeline reference model (elapsed
// cycles per channel, queue of samples, integer floor averaging) checked
// against the DUT every cycle, plus literal expectations for the scan
// latency, wrap-around and negative-fraction averages, error handling and
// reset. Builds with or without DMTD_SCAN_RETRY_EN.
module tb_dmtd_scan_ctl;
    localparam int DW     = 14;
    localparam int PW     = DW - 1;
    localparam int NCH    = 4;
    localparam int SETTLE = 16;
    localparam int PER    = 4;
    localparam int NAVG   = 2;
    localparam int MAXR   = 3;
    localparam int N      = 1 << NAVG;
    localparam int M      = 1 << PW;
`ifdef DMTD_SCAN_RETRY_EN
    localparam int ALLOWED = MAXR;
`else
    localparam int ALLOWED = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmtd_scan_ctl_if #(.dw(DW), .nch(NCH)) bus ();

    dmtd_scan_ctl #(
        .dw(DW), .nch(NCH), .settle(SETTLE), .sample_per(PER),
        .navg_log2(NAVG), .max_retry(MAXR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state: mode 0 idle, 1 measuring, 2 finishing channel
    int  m_mode = 0;
    int  m_t = 0;
    int  m_retry = 0;
    int  m_avg = 0;
    bit  m_failed = 1'b0;
    bit  m_run_prev = 1'b0;
    bit  mr, mrise;
    int  m_samp[$];
    int  e_sel = 0;
    int  e_result = 0;
    int  e_result_ch = 0;
    bit  e_busy = 1'b0;
    bit  e_rv = 1'b0;
    bit  e_fail = 1'b0;
    logic [NCH-1:0] e_mask = '0;

    // stimulus control
    int pmode = 0;
    int cval = 0;
    int emode = 0;
    int center = 0;
    bit pulsed = 1'b0;
    int plan[NCH][N];
    int got_kind[NCH];
    int got_res[NCH];
    int first_lat = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // average of samples around the first one, differences taken on the circle
    function automatic int wrap_avg(input int s[$]);
        int r, sum, d, q;
        r = s[0];
        sum = 0;
        foreach (s[i]) begin
            d = ((s[i] - r) % M + M) % M;
            if (d >= M / 2) d -= M;
            sum += d;
        end
        q = sum / N;
        if ((sum % N != 0) && (sum < 0)) q--;
        return ((r + q) % M + M) % M;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_retry = 0; m_avg = 0;
            m_failed = 1'b0; m_run_prev = 1'b0; m_samp.delete();
            e_sel = 0; e_result = 0; e_result_ch = 0;
            e_busy = 1'b0; e_rv = 1'b0; e_fail = 1'b0; e_mask = '0;
        end else begin
            mr = bus.run;
            mrise = mr && !m_run_prev;
            e_rv = 1'b0;
            e_fail = 1'b0;
            if (mrise) e_mask = '0;
            case (m_mode)
                0: if (mr) begin
                    if (mrise) e_sel = 0;
                    m_mode = 1; m_t = 0; m_samp.delete(); e_busy = 1'b1;
                end
                1: if (bus.err_in) begin
                    if (m_retry < ALLOWED) begin
                        m_retry++; m_t = 0; m_samp.delete();
                    end else begin
                        m_failed = 1'b1; m_mode = 2;
                    end
                end else begin
                    if (m_t >= SETTLE && (m_t - SETTLE) % PER == PER - 1) begin
                        m_samp.push_back(int'(bus.phdiff_in));
                        if (m_samp.size() == N) begin
                            m_avg = wrap_avg(m_samp);
                            m_mode = 2;
                        end
                    end
                    m_t++;
                end
                default: begin
                    if (m_failed) begin
                        e_fail = 1'b1;
                        e_mask[e_sel] = 1'b1;
                    end else begin
                        e_rv = 1'b1;
                        e_result = m_avg;
                    end
                    e_result_ch = e_sel;
                    m_retry = 0;
                    m_failed = 1'b0;
                    e_sel = (e_sel + 1) % NCH;
                    if (mr) begin
                        m_mode = 1; m_t = 0; m_samp.delete();
                    end else begin
                        m_mode = 0; e_busy = 1'b0;
                    end
                end
            endcase
            m_run_prev = mr;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("sel", 32'(bus.sel), 32'(e_sel));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("result", 32'(bus.result), 32'(e_result));
        chk("result_ch", 32'(bus.result_ch), 32'(e_result_ch));
        chk("result_valid", 32'(bus.result_valid), 32'(e_rv));
        chk("fail", 32'(bus.fail), 32'(e_fail));
        chk("fail_mask", 32'(bus.fail_mask), 32'(e_mask));
    end

    task automatic tick();
        int idx;
        @(negedge clk);
        case (pmode)
            0: bus.phdiff_in = PW'(cval);
            1: begin
                idx = m_samp.size();
                if (idx < N) bus.phdiff_in = PW'(plan[e_sel][idx]);
            end
            default: begin
                if ($urandom_range(0, 99) == 0) center = int'($urandom_range(0, M - 1));
                bus.phdiff_in = PW'((center + int'($urandom_range(0, 40)) - 20 + M) % M);
            end
        endcase
        case (emode)
            0: bus.err_in = 1'b0;
            1: begin
                if (!pulsed && e_sel == 1 && m_mode == 1 && m_samp.size() == 2) begin
                    bus.err_in = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    bus.err_in = (e_sel == 2 && m_mode == 1);
                end
            end
            default: bus.err_in = ($urandom_range(0, 299) == 0);
        endcase
    endtask

    task automatic do_scan(input bit drop3, input int budget);
        int n = 0;
        for (int c = 0; c < NCH; c++) begin
            got_kind[c] = 0;
            got_res[c] = -1;
        end
        first_lat = -1;
        bus.run = 1'b1;
        while (1) begin
            tick();
            n++;
            if (bus.result_valid === 1'b1) begin
                if (first_lat < 0) first_lat = n;
                got_kind[bus.result_ch] = 1;
                got_res[bus.result_ch] = int'(bus.result);
            end
            if (bus.fail === 1'b1) got_kind[bus.result_ch] = 2;
            if (drop3 && bus.run && e_sel == 3 && m_mode == 1 && m_t == SETTLE + 6) bus.run = 1'b0;
            if (!bus.run && m_mode == 0) break;
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL scan_timeout: got %0d cycles without finishing, expected under %0d", n, budget);
                bus.run = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int exp_b[NCH];
        int exp_kind[NCH];
        logic [NCH-1:0] exp_mask;
        bus.run = 1'b0;
        bus.phdiff_in = '0;
        bus.err_in = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < N; s++) plan[c][s] = 1000;
        plan[1][0] = 8191; plan[1][1] = 0;    plan[1][2] = 1;    plan[1][3] = 0;
        plan[2][0] = 100;  plan[2][1] = 99;   plan[2][2] = 99;   plan[2][3] = 99;
        plan[3][0] = 5000; plan[3][1] = 5003; plan[3][2] = 4990; plan[3][3] = 5001;
        exp_b[0] = 1000; exp_b[1] = 0; exp_b[2] = 99; exp_b[3] = 4998;

        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_sel", 32'(bus.sel), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_result", 32'(bus.result), 0);
        chk("reset_valid", 32'(bus.result_valid), 0);
        chk("reset_mask", 32'(bus.fail_mask), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // constant phase, stop requested in the middle of ch3 acquisition
        pmode = 0; cval = 1000; emode = 0;
        do_scan(1'b1, 400);
        chk("first_strobe_latency", 32'(first_lat), 34);
        for (int c = 0; c < NCH; c++) begin
            chk("A_kind", 32'(got_kind[c]), 1);
            chk("A_result", 32'(got_res[c]), 1000);
        end
        chk("A_stop_busy", 32'(bus.busy), 0);
        chk("A_stop_sel", 32'(bus.sel), 0);
        repeat (3) tick();

        // hand-planned samples: wrap-around and negative fractions
        pmode = 1;
        do_scan(1'b1, 400);
        for (int c = 0; c < NCH; c++) begin
            chk("B_kind", 32'(got_kind[c]), 1);
            chk("B_result", 32'(got_res[c]), 32'(exp_b[c]));
        end
        repeat (3) tick();

        // single error pulse on ch1, held error on ch2
        pmode = 0; cval = 2000; emode = 1; pulsed = 1'b0;
        do_scan(1'b1, 800);
`ifdef DMTD_SCAN_RETRY_EN
        exp_kind[0] = 1; exp_kind[1] = 1; exp_kind[2] = 2; exp_kind[3] = 1;
        exp_mask = 4'b0100;
`else
        exp_kind[0] = 1; exp_kind[1] = 2; exp_kind[2] = 2; exp_kind[3] = 1;
        exp_mask = 4'b0110;
`endif
        for (int c = 0; c < NCH; c++) begin
            chk("C_kind", 32'(got_kind[c]), 32'(exp_kind[c]));
            if (exp_kind[c] == 1) chk("C_result", 32'(got_res[c]), 2000);
        end
        chk("C_fail_mask", 32'(bus.fail_mask), 32'(exp_mask));

        // mask clears on run rise, then random phase, errors and run toggling
        emode = 0;
        tick();
        bus.run = 1'b1;
        tick();
        chk("mask_clear_on_run", 32'(bus.fail_mask), 0);
        pmode = 2; emode = 2; center = M - 5;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 399) == 0) bus.run = !bus.run;
        end
        bus.run = 1'b0;
        emode = 0;
        k = 0;
        while (m_mode != 0 && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL random_stop_timeout: got %0d cycles busy, expected under 300", k);
        end
        tick();
        chk("D_idle_busy", 32'(bus.busy), 0);

        // asynchronous reset in the middle of SETTLE
        pmode = 0; cval = 1234;
        bus.run = 1'b1;
        k = 0;
        while (!(m_mode == 1 && m_t == 5) && k < 50) begin
            tick();
            k++;
        end
        chk("E_in_settle_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("E_rst_sel", 32'(bus.sel), 0);
        chk("E_rst_busy", 32'(bus.busy), 0);
        chk("E_rst_result", 32'(bus.result), 0);
        chk("E_rst_result_ch", 32'(bus.result_ch), 0);
        chk("E_rst_valid", 32'(bus.result_valid), 0);
        chk("E_rst_fail", 32'(bus.fail), 0);
        chk("E_rst_mask", 32'(bus.fail_mask), 0);
        bus.run = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
